// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: ALU writeback request, load-return request,
// and the registered write port plus queue status returned by the arbiter.
// master = requester/observer side, slave = arbiter side.
//
// Ports (signals):
//   alu_valid/alu_ready/alu_addr/alu_data  ALU writeback handshake
//   mem_valid/mem_addr/mem_data            load return, always accepted
//   wr_en/wr_addr/wr_data                  registered register-file write port
//   pending                                per-register "live ALU write queued" bitmap
//   qcount                                 occupied holding-queue slots
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [31:0]       pending;
  logic [2:0]        qcount;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready,
    input  wr_en, wr_addr, wr_data,
    input  pending, qcount
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready,
    output wr_en, wr_addr, wr_data,
    output pending, qcount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the single register-file write port between load returns (priority) and ALU writebacks.
// Latency: load 1 cycle; ALU >= 2 cycles via holding queue (1 cycle with RF_WB_BYPASS_EN on an idle port).
// Backpressure: alu_ready low only when the holding queue is full; load returns are never stalled.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; empties the queue and clears the write port
//   bus    regfile_write_arbiter_if.slave (ALU request, load return, write port, pending, qcount)
//
// Optional feature macro: RF_WB_BYPASS_EN -- lets an ALU result go straight to the
// write port when the queue is empty and no load return is presented that cycle.
//
// Register 31 is hard-wired zero: requests targeting it are consumed and discarded.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int                PW       = (QDEPTH > 2) ? 2 : 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
  localparam logic [2:0]        FULL_CNT = 3'(QDEPTH);

  // Holding queue storage. q_occ marks an occupied slot; q_live marks an
  // occupied slot whose write has not been superseded by a younger load.
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [QDEPTH-1:0] q_occ;
  logic [QDEPTH-1:0] q_live;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2:0]        count;

  // Registered write port
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Per-cycle decisions
  logic              q_full;
  logic              q_empty;
  logic              mem_win;
  logic              alu_acc;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              head_live;
  logic [QDEPTH-1:0] squash;
  logic [QDEPTH-1:0] q_occ_nxt;
  logic [QDEPTH-1:0] q_live_nxt;
  logic [2:0]        count_nxt;
  logic              nxt_en;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic [31:0]       pending_c;

  assign q_full  = (count == FULL_CNT);
  assign q_empty = (count == 3'd0);

  // Fullness is judged before this cycle's pop, so a full queue never takes
  // a push even when the head drains in the same cycle.
  assign bus.alu_ready = !q_full;

  assign mem_win = bus.mem_valid && (bus.mem_addr != ZERO_REG);
  assign alu_acc = bus.alu_valid && (bus.alu_addr != ZERO_REG) && !q_full;

`ifdef RF_WB_BYPASS_EN
  // Straight-through path only when nothing older is waiting and no load is
  // presented at all (even one to register 31).
  assign bypass = alu_acc && q_empty && !bus.mem_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push      = alu_acc && !bypass;
  assign pop       = !mem_win && !q_empty;
  assign head_live = q_live[head];

  // A load is younger than anything already queued, so it kills every live
  // queued write to the same register. The entry pushed this cycle is younger
  // still and is inserted after the squash, so it stays live.
  always_comb begin
    squash = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (mem_win && q_occ[i] && (q_addr[i] == bus.mem_addr)) begin
        squash[i] = 1'b1;
      end
    end
  end

  always_comb begin
    q_occ_nxt  = q_occ;
    q_live_nxt = q_live & ~squash;
    if (pop) begin
      q_occ_nxt[head]  = 1'b0;
      q_live_nxt[head] = 1'b0;
    end
    // push and pop never hit the same slot: push needs a non-full queue and
    // pop a non-empty one, so tail differs from head whenever both occur.
    if (push) begin
      q_occ_nxt[tail]  = 1'b1;
      q_live_nxt[tail] = 1'b1;
    end
  end

  assign count_nxt = count + {2'b00, push} - {2'b00, pop};

  // Port selection: load, then live queue head, then bypassed ALU result.
  // A squashed head pops with nxt_en low.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_addr = wr_addr_q;
    nxt_data = wr_data_q;
    if (mem_win) begin
      nxt_en   = 1'b1;
      nxt_addr = bus.mem_addr;
      nxt_data = bus.mem_data;
    end else if (pop && head_live) begin
      nxt_en   = 1'b1;
      nxt_addr = q_addr[head];
      nxt_data = q_data[head];
    end else if (bypass) begin
      nxt_en   = 1'b1;
      nxt_addr = bus.alu_addr;
      nxt_data = bus.alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      q_occ     <= '0;
      q_live    <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= 3'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      wr_en_q <= nxt_en;
      if (nxt_en) begin
        wr_addr_q <= nxt_addr;
        wr_data_q <= nxt_data;
      end
      q_occ  <= q_occ_nxt;
      q_live <= q_live_nxt;
      count  <= count_nxt;
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push) begin
        q_addr[tail] <= bus.alu_addr;
        q_data[tail] <= bus.alu_data;
        tail         <= tail + PW'(1);
      end
    end
  end

  // pending is a pure function of the queue registers, so it only moves on a
  // clock edge or reset like the other registered outputs.
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_occ[i] && q_live[i]) begin
        pending_c[q_addr[i]] = 1'b1;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.pending = pending_c;
  assign bus.qcount  = count;

endmodule
